// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
// Used by the fetch sequencer and by the reusable branch target unit.
package fetch_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } fetch_state_t;

    typedef enum logic [1:0] {
        RK_B    = 2'd0,
        RK_COND = 2'd1,
        RK_BR   = 2'd2,
        RK_RSVD = 2'd3
    } redirect_kind_t;

    localparam int INSTR_BYTES = 4;

endpackage

// File: rtl/fetch_sequencer_branch_target.sv
// Combinational control-transfer target computation.
// Shared between the fetch front end and the execute stage.
module branch_target
    import fetch_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic [1:0]       i_kind,
    input  logic [WIDTH-1:0] i_pc,
    input  logic [25:0]      i_imm,
    input  logic [WIDTH-1:0] i_reg,
    output logic             o_taken,
    output logic [WIDTH-1:0] o_target,
    output logic             o_align_err
);

    logic [WIDTH-1:0] w_off26;
    logic [WIDTH-1:0] w_off19;

    assign w_off26 = {{(WIDTH-28){i_imm[25]}}, i_imm, 2'b00};
    assign w_off19 = {{(WIDTH-21){i_imm[18]}}, i_imm[18:0], 2'b00};

    // Select target by kind; reserved kind reports not-taken
    always_comb begin
        o_taken     = 1'b0;
        o_target    = i_pc;
        o_align_err = 1'b0;
        unique case (redirect_kind_t'(i_kind))
            RK_B: begin
                o_taken  = 1'b1;
                o_target = i_pc + w_off26;
            end
            RK_COND: begin
                o_taken  = 1'b1;
                o_target = i_pc + w_off19;
            end
            RK_BR: begin
                o_taken     = 1'b1;
                o_target    = {i_reg[WIDTH-1:2], 2'b00};
                o_align_err = |i_reg[1:0];
            end
            RK_RSVD: begin
                o_taken = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch front end: PC register, fetch FSM and decode buffer.
// One outstanding memory read at a time; redirects squash wrong-path work.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int              WIDTH    = 64,
    parameter int              INSTR_W  = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req,
    output logic [WIDTH-1:0]   imem_addr,
    input  logic               imem_gnt,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr,
    output logic [WIDTH-1:0]   instr_pc,
    input  logic               instr_ready,
    input  logic               redirect_valid,
    input  logic [1:0]         redirect_kind,
    input  logic [WIDTH-1:0]   redirect_pc,
    input  logic [25:0]        redirect_imm,
    input  logic [WIDTH-1:0]   redirect_reg,
    output logic               align_err
);

    fetch_state_t       r_state;
    logic [WIDTH-1:0]   r_pc;
    logic [WIDTH-1:0]   r_instr_pc;
    logic [INSTR_W-1:0] r_instr;
    logic               r_instr_valid;
    logic               r_align_err;

    logic               w_bt_taken;
    logic               w_bt_align;
    logic [WIDTH-1:0]   w_target;
    logic               w_redirect;

    branch_target #(
        .WIDTH (WIDTH)
    ) u_branch_target (
        .i_kind      (redirect_kind),
        .i_pc        (redirect_pc),
        .i_imm       (redirect_imm),
        .i_reg       (redirect_reg),
        .o_taken     (w_bt_taken),
        .o_target    (w_target),
        .o_align_err (w_bt_align)
    );

    assign w_redirect  = redirect_valid & w_bt_taken;
    assign imem_req    = ~reset & (r_state == FETCH);
    assign imem_addr   = r_pc;
    assign instr_valid = r_instr_valid;
    assign instr       = r_instr;
    assign instr_pc    = r_instr_pc;
    assign align_err   = r_align_err;

    // Fetch FSM; a redirect overrides every other event in its cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= FETCH;
            r_pc          <= RESET_PC;
            r_instr_valid <= 1'b0;
            r_instr       <= '0;
            r_instr_pc    <= '0;
            r_align_err   <= 1'b0;
        end else begin
            r_align_err <= 1'b0;
            if (w_redirect) begin
                r_pc          <= w_target;
                r_align_err   <= w_bt_align;
                r_instr_valid <= 1'b0;
                unique case (r_state)
                    FETCH: r_state <= imem_gnt ? DRAIN : FETCH;
                    WAIT:  r_state <= imem_rvalid ? FETCH : DRAIN;
                    HOLD:  r_state <= FETCH;
                    DRAIN: r_state <= imem_rvalid ? FETCH : DRAIN;
                endcase
            end else begin
                unique case (r_state)
                    FETCH: begin
                        if (imem_gnt) begin
                            r_state <= WAIT;
                        end
                    end
                    WAIT: begin
                        if (imem_rvalid) begin
                            r_instr       <= imem_rdata;
                            r_instr_pc    <= r_pc;
                            r_instr_valid <= 1'b1;
                            r_pc          <= r_pc + WIDTH'(INSTR_BYTES);
                            r_state       <= HOLD;
                        end
                    end
                    HOLD: begin
                        if (instr_ready) begin
                            r_instr_valid <= 1'b0;
                            r_state       <= FETCH;
                        end
                    end
                    DRAIN: begin
                        if (imem_rvalid) begin
                            r_state <= FETCH;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Instruction-fetch front end. Owns the architectural PC, issues word reads to instruction memory over a req/gnt + rvalid handshake, and presents one fetched instruction at a time to decode over a valid/ready handshake.
- Computes the next PC: sequential PC+4, or redirect targets for B (imm26), B.cond/CBZ (imm19) and BR (register), signalled by the execute stage.

Parameters:
- WIDTH, 64, PC and address width in bits.
- INSTR_W, 32, instruction width in bits.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- imem_req  output  1  fetch request valid.
- imem_addr  output  WIDTH  fetch address; equals the current PC.
- imem_gnt  input  1  memory accepts the request this cycle.
- imem_rvalid  input  1  read data valid.
- imem_rdata  input  INSTR_W  read data.
- instr_valid  output  1  instruction available to decode.
- instr  output  INSTR_W  held instruction.
- instr_pc  output  WIDTH  PC of the held instruction.
- instr_ready  input  1  decode consumes the instruction this cycle.
- redirect_valid  input  1  single-cycle pulse; a taken control transfer.
- redirect_kind  input  2  0=B, 1=B.cond/CBZ, 2=BR, 3=reserved (ignored).
- redirect_pc  input  WIDTH  PC of the branch instruction.
- redirect_imm  input  26  immediate field; kind 1 uses bits [18:0].
- redirect_reg  input  WIDTH  register operand for BR.
- align_err  output  1  one-cycle pulse: BR target had bits [1:0] nonzero.

Behaviour:
- Reset: synchronous and active-high.
  - Loads pc=RESET_PC and state=FETCH.
  - Clears instr_valid, instr and instr_pc (all 0), and align_err.
  - imem_req=0 while reset is high.
  - Instruction memory shares this reset, so no response is outstanding after reset.
- States: FETCH, WAIT, HOLD, DRAIN.
- FETCH:
  - Drive imem_req=1, imem_addr=pc.
  - imem_gnt=1 -> WAIT.
  - imem_req holds, with a stable address, until granted.
- WAIT:
  - imem_req=0.
  - imem_rvalid=1 -> capture instr<=imem_rdata and instr_pc<=pc, set instr_valid=1, pc<=pc+4, go to HOLD.
- HOLD:
  - instr_valid=1, with instr and instr_pc stable.
  - instr_ready=1 -> clear instr_valid, go to FETCH.
  - instr_ready is ignored when instr_valid=0.
- DRAIN:
  - imem_req=0.
  - Wait for imem_rvalid, discard the data -> FETCH.
- Minimum latency: grant at cycle t, rvalid at t+1 gives instr_valid at t+2. Steady state is 1 instruction per 3 cycles with zero-wait memory.
- Target arithmetic: computed in WIDTH bits, modulo 2^WIDTH (wrap-around silent).
  - kind 0: redirect_pc + (sext(imm[25:0]) << 2).
  - kind 1: redirect_pc + (sext(imm[18:0]) << 2).
  - kind 2: {redirect_reg[WIDTH-1:2], 2'b00}; pulse align_err the next cycle if redirect_reg[1:0] != 0.
  - kind 3: no effect at all.
  - pc+4 also wraps modulo 2^WIDTH.
- Redirect has highest priority over every other event in the same cycle; pc<=target in all states.
  - FETCH, not granted: stay in FETCH. The next request uses the target.
  - FETCH, granted the same cycle: go to DRAIN (the granted old address is discarded).
  - WAIT, no rvalid: go to DRAIN.
  - WAIT, rvalid the same cycle: drop the data, go to FETCH, instr_valid stays 0.
  - HOLD: clear instr_valid (wrong-path instruction squashed, even if instr_ready=1 that cycle), go to FETCH.
  - DRAIN: update pc, stay in DRAIN (or go to FETCH if rvalid the same cycle).
- imem_rvalid in FETCH or HOLD is a protocol error and is ignored.

Decomposition:
- Shared package fetch_pkg:
  - enum fetch_state_t {FETCH, WAIT, HOLD, DRAIN}.
  - enum redirect_kind_t {RK_B=0, RK_COND=1, RK_BR=2, RK_RSVD=3}.
  - constant INSTR_BYTES=4.
- Sub-module branch_target: combinational target and align_err-raw from kind, pc, imm and reg. It is reused later by the execute stage.
- The top level holds the PC register, the output buffer and the FSM.

Test Plan:
- Reset then zero-wait memory, gnt=1, rvalid one cycle later, ready=1 -> addresses 0x0, 0x4, 0x8 issued; instr_pc matches; instr_valid every 3rd cycle.
- Decode stall: ready=0 for 5 cycles in HOLD -> instr/instr_pc stable, imem_req=0, no new request; on ready=1 the next request is at instr_pc+4.
- B redirect in WAIT: redirect_pc=0x100, kind=0, imm26=0x3FFFFFE (-2) -> DRAIN discards the pending word; next imem_addr=0xF8; no instr_valid for the discarded word.
- CBZ redirect in HOLD with ready=1 the same cycle: pc=0x40, imm19=0x10 -> instr_valid drops, instruction not consumed; next fetch at 0x80.
- BR with redirect_reg=0x2003 in FETCH, not granted -> align_err pulses one cycle; next imem_addr=0x2000. Kind 3 pulse -> no change to state or pc.
- Wrap and reset mid-operation:
  - pc=0xFFFF_FFFF_FFFF_FFFC fetch -> next address 0x0.
  - Assert reset in WAIT -> next cycle pc=RESET_PC, state FETCH, instr_valid=0.
